// File: rtl/tdm_chan_mux.sv
// N:1 time-division channel multiplexer with a single registered output stage.
// Fixed-select or round-robin arbitration, valid/ready on every port.
module tdm_chan_mux #(
   parameter int WIDTH = 10,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             load;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   int               rr_idx;

   assign load = !out_valid_q || out_ready;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      if (!mode) begin
         // Out-of-range sel matches no channel, so it can never grant.
         for (int i = 0; i < NCH; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
            for (int j = 0; j < NCH; j++) begin
               if (!grant_vld && j == rr_idx && in_valid[j]) begin
                  grant_vld = 1'b1;
                  grant_idx = SELW'(j);
               end
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         in_ready[i] = !rst && load && grant_vld && (grant_idx == SELW'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_ch_d = grant_idx;
            for (int i = 0; i < NCH; i++) begin
               if (grant_idx == SELW'(i)) out_data_d = in_data[i*WIDTH +: WIDTH];
            end
            // Explicit wrap keeps non-power-of-two channel counts correct.
            if (mode) begin
               ptr_d = (int'(grant_idx) == NCH-1) ? '0 : grant_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_tdm_chan_mux.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural arbitration model; a 3-channel build covers pointer wrap.
module tb_tdm_chan_mux;
   localparam int W = 10;
   localparam int N = 4;
   localparam int S = 2;
   localparam int N3 = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_ready;
   logic           mode, out_valid, out_ready;
   logic [S-1:0]   sel, out_ch;
   logic [W-1:0]   out_data;

   logic [N3*W-1:0] b_in_data;
   logic [N3-1:0]   b_in_valid, b_in_ready;
   logic            b_mode, b_out_valid, b_out_ready;
   logic [S-1:0]    b_sel, b_out_ch;
   logic [W-1:0]    b_out_data;

   tdm_chan_mux #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready));

   tdm_chan_mux #(.WIDTH(W), .NCH(N3), .SELW(S)) dut3 (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
      .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: the output register seen as a one-word buffer and a
   // fairness pointer, advanced from the rules at the end of every cycle.
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_ch, m_ptr;

   always @(negedge clk) begin
      int  g;
      bit  ld;
      logic [N-1:0] exp_rdy;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_ready", in_ready, 0);
      end else begin
         chk("out_valid", out_valid, m_valid);
         chk("out_data", out_data, m_data);
         chk("out_ch", out_ch, m_ch);
         ld = !m_valid || out_ready;
         g = -1;
         if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) g = int'(sel);
         end else begin
            for (int k = 0; k < N; k++)
               if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         exp_rdy = (ld && g >= 0) ? N'(1) << g : '0;
         chk("in_ready", in_ready, exp_rdy);
         if (ld) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
               m_data = in_data[g*W +: W];
               m_ch   = g;
               if (mode) m_ptr = (g + 1) % N;
            end
         end
      end
   end

   initial begin
      int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
      int exp_sk[3] = '{1, 3, 1};
      logic [N-1:0] exp_skr[3] = '{4'b0010, 4'b1000, 4'b0010};
      int exp_b[4] = '{0, 1, 2, 0};

      rst = 1'b1;
      in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      b_in_data = '0; b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
      step(); step();
      rst = 1'b0;

      // Fixed select
      mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
      in_data = {10'h0AA, 10'h155, 10'h011, 10'h022};
      #1 chk("fix_ready_sel2", in_ready, 4'b0100);
      step();
      chk("fix_data", out_data, 10'h155);
      chk("fix_ch", out_ch, 2);
      chk("fix_valid", out_valid, 1);
      sel = 2'd3;
      #1 chk("fix_ready_sel3", in_ready, 4'b1000);
      step();
      chk("fix_data3", out_data, 10'h0AA);

      // Round-robin fairness, pointer still 0 after fixed-mode traffic
      mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_ch", out_ch, exp_rr[k]);
         chk("rr_valid", out_valid, 1);
      end

      // Round-robin skip from a fresh pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1 chk("skip_ready", in_ready, exp_skr[k]);
         step();
         chk("skip_ch", out_ch, exp_sk[k]);
      end

      // Backpressure
      mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[0 +: W] = 10'h3FF;
      step();
      chk("bp_load", out_data, 10'h3FF);
      out_ready = 1'b0; in_data[0 +: W] = 10'h001;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ready", in_ready, 0);
         step();
         chk("bp_data", out_data, 10'h3FF);
         chk("bp_ch", out_ch, 0);
         chk("bp_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", in_ready, 4'b0001);
      step();
      chk("bp_new_data", out_data, 10'h001);

      // Asynchronous reset with a word held
      rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_ch", out_ch, 0);
      chk("arst_ready", in_ready, 0);
      step();
      rst = 1'b0; mode = 1'b1; in_valid = 4'hF;
      step();
      chk("arst_first_rr", out_ch, 0);
      chk("arst_first_valid", out_valid, 1);

      // Random traffic, checked by the model every cycle
      for (int c = 0; c < 600; c++) begin
         in_valid  = N'($urandom_range(0, 15));
         mode      = 1'(($urandom_range(0, 7) == 0) ? ~mode : mode);
         sel       = S'($urandom_range(0, 3));
         out_ready = 1'($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
         step();
      end

      // Three-channel build: wrap and out-of-range select
      in_valid = '0; out_ready = 1'b1;
      b_mode = 1'b1; b_in_valid = 3'b111;
      b_in_data = {10'h333, 10'h222, 10'h111};
      for (int k = 0; k < 4; k++) begin
         step();
         chk("n3_ch", b_out_ch, exp_b[k]);
      end
      chk("n3_data", b_out_data, 10'h111);
      b_mode = 1'b0; b_sel = 2'd3;
      #1 chk("n3_sel3_ready", b_in_ready, 0);
      step();
      chk("n3_drain_valid", b_out_valid, 0);
      chk("n3_hold_ch", b_out_ch, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
